// File: rtl/dual_port_ram_burst.sv
// True-dual-port RAM with configurable read latency, range checking,
// deterministic same-address write resolution and a per-port burst-read
// sequencer that streams consecutive (wrapping) words from one start pulse.
// Ports (A shown, B identical with a->b):
//   clk, rst_n                        clock, async active-low reset
//   rea, wea, addra, dina             single read / write request
//   bursta_start/_addr/_len           burst start pulse, start address, word count
//   douta, dvalida                    read data (0 when not valid) and valid
//   bursta_busy, bursta_done          burst in progress, last burst word valid

// Per-port request arbitration, burst sequencer and read pipeline.
module dprb_port #(
  parameter int unsigned RAM_DEEP   = 40,
  parameter int unsigned DWIDTH     = 16,
  parameter int unsigned AWIDTH     = 6,
  parameter int unsigned LWIDTH     = 7,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              re,
  input  logic              we,
  input  logic [AWIDTH-1:0] addr,
  input  logic              burst_start,
  input  logic [AWIDTH-1:0] burst_addr,
  input  logic [LWIDTH-1:0] burst_len,
  input  logic [DWIDTH-1:0] rd_word,
  output logic [AWIDTH-1:0] rd_addr_c,
  output logic              wr_en_c,
  output logic [DWIDTH-1:0] dout,
  output logic              dvalid,
  output logic              busy,
  output logic              done
);

  localparam logic [AWIDTH:0]   DEEP      = (AWIDTH+1)'(RAM_DEEP);
  localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(RAM_DEEP - 1);

  typedef enum logic {S_IDLE, S_BURST} state_t;

  typedef struct packed {
    logic              valid;
    logic              last;
    logic [DWIDTH-1:0] data;
  } rd_beat_t;

  state_t            state, state_n;
  logic [AWIDTH-1:0] cur_addr, cur_addr_n;
  logic [LWIDTH-1:0] remain, remain_n;
  logic              issue_c;
  logic              last_c;
  rd_beat_t          beat_c;
  rd_beat_t          pipe [RD_LATENCY];

  // Sequencer state register; busy tracks the next state so it is a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cur_addr <= '0;
      remain   <= '0;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      cur_addr <= cur_addr_n;
      remain   <= remain_n;
      busy     <= (state_n == S_BURST);
    end
  end

  // Next state, issue selection and write qualification.
  always_comb begin
    state_n    = state;
    cur_addr_n = cur_addr;
    remain_n   = remain;
    issue_c    = 1'b0;
    last_c     = 1'b0;
    rd_addr_c  = addr;
    wr_en_c    = 1'b0;
    case (state)
      S_IDLE: begin
        issue_c = re;
        wr_en_c = we && ({1'b0, addr} < DEEP);
        if (burst_start && (burst_len != '0) && ({1'b0, burst_addr} < DEEP)) begin
          state_n    = S_BURST;
          cur_addr_n = burst_addr;
          remain_n   = burst_len;
        end
      end
      S_BURST: begin
        issue_c    = 1'b1;
        rd_addr_c  = cur_addr;
        cur_addr_n = (cur_addr == LAST_ADDR) ? '0 : cur_addr + AWIDTH'(1);
        remain_n   = remain - LWIDTH'(1);
        if (remain == LWIDTH'(1)) begin
          last_c  = 1'b1;
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Out-of-range single reads still return a valid beat, with zero data.
  always_comb begin
    beat_c       = '0;
    beat_c.valid = issue_c;
    beat_c.last  = last_c;
    if (issue_c && ({1'b0, rd_addr_c} < DEEP)) beat_c.data = rd_word;
  end

  // Read pipeline; the done tag travels with the final burst beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(RD_LATENCY); i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= beat_c;
      for (int i = 1; i < int'(RD_LATENCY); i++) pipe[i] <= pipe[i-1];
    end
  end

  assign dout   = pipe[RD_LATENCY-1].data;
  assign dvalid = pipe[RD_LATENCY-1].valid;
  assign done   = pipe[RD_LATENCY-1].valid && pipe[RD_LATENCY-1].last;

endmodule

module dual_port_ram_burst #(
  parameter int unsigned RAM_DEEP       = 40,
  parameter int unsigned DWIDTH         = 16,
  parameter int unsigned AWIDTH         = $clog2(RAM_DEEP),
  parameter int unsigned LWIDTH         = AWIDTH + 1,
  parameter int unsigned RD_LATENCY     = 1,
  parameter int unsigned COLLISION_MODE = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rea,
  input  logic              wea,
  input  logic [AWIDTH-1:0] addra,
  input  logic [DWIDTH-1:0] dina,
  input  logic              bursta_start,
  input  logic [AWIDTH-1:0] bursta_addr,
  input  logic [LWIDTH-1:0] bursta_len,
  output logic [DWIDTH-1:0] douta,
  output logic              dvalida,
  output logic              bursta_busy,
  output logic              bursta_done,
  input  logic              reb,
  input  logic              web,
  input  logic [AWIDTH-1:0] addrb,
  input  logic [DWIDTH-1:0] dinb,
  input  logic              burstb_start,
  input  logic [AWIDTH-1:0] burstb_addr,
  input  logic [LWIDTH-1:0] burstb_len,
  output logic [DWIDTH-1:0] doutb,
  output logic              dvalidb,
  output logic              burstb_busy,
  output logic              burstb_done
);

  localparam bit B_WINS = (COLLISION_MODE != 0);

  logic [DWIDTH-1:0] mem [RAM_DEEP];
  logic [AWIDTH-1:0] rd_addr_a_c, rd_addr_b_c;
  logic              wr_a_c, wr_b_c, same_c;

  dprb_port #(
    .RAM_DEEP(RAM_DEEP), .DWIDTH(DWIDTH), .AWIDTH(AWIDTH),
    .LWIDTH(LWIDTH), .RD_LATENCY(RD_LATENCY)
  ) u_port_a (
    .clk(clk), .rst_n(rst_n), .re(rea), .we(wea), .addr(addra),
    .burst_start(bursta_start), .burst_addr(bursta_addr), .burst_len(bursta_len),
    .rd_word(mem[rd_addr_a_c]), .rd_addr_c(rd_addr_a_c), .wr_en_c(wr_a_c),
    .dout(douta), .dvalid(dvalida), .busy(bursta_busy), .done(bursta_done)
  );

  dprb_port #(
    .RAM_DEEP(RAM_DEEP), .DWIDTH(DWIDTH), .AWIDTH(AWIDTH),
    .LWIDTH(LWIDTH), .RD_LATENCY(RD_LATENCY)
  ) u_port_b (
    .clk(clk), .rst_n(rst_n), .re(reb), .we(web), .addr(addrb),
    .burst_start(burstb_start), .burst_addr(burstb_addr), .burst_len(burstb_len),
    .rd_word(mem[rd_addr_b_c]), .rd_addr_c(rd_addr_b_c), .wr_en_c(wr_b_c),
    .dout(doutb), .dvalid(dvalidb), .busy(burstb_busy), .done(burstb_done)
  );

  assign same_c = wr_a_c && wr_b_c && (addra == addrb);

  // Storage is not reset; on a same-address dual write only the winner lands.
  always_ff @(posedge clk) begin
    if (wr_a_c && !(same_c && B_WINS))  mem[addra] <= dina;
    if (wr_b_c && !(same_c && !B_WINS)) mem[addrb] <= dinb;
  end

endmodule

// File: tb/tb_dual_port_ram_burst.sv
// Bench for dual_port_ram_burst: two instances (latency 1 / port A wins,
// latency 3 / port B wins) share one stimulus stream and are checked against
// a transaction-level reference model.
module tb_dual_port_ram_burst;

  localparam int DEEP = 40;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rea, wea, reb, web;
  logic [5:0]  addra, addrb, bursta_addr, burstb_addr;
  logic [15:0] dina, dinb;
  logic        bursta_start, burstb_start;
  logic [6:0]  bursta_len, burstb_len;

  logic [15:0] douta0, doutb0, douta1, doutb1;
  logic        dvalida0, dvalidb0, bursta_busy0, burstb_busy0, bursta_done0, burstb_done0;
  logic        dvalida1, dvalidb1, bursta_busy1, burstb_busy1, bursta_done1, burstb_done1;

  always #5 clk = ~clk;

  dual_port_ram_burst #(.RD_LATENCY(1), .COLLISION_MODE(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .rea(rea), .wea(wea), .addra(addra), .dina(dina),
    .bursta_start(bursta_start), .bursta_addr(bursta_addr), .bursta_len(bursta_len),
    .douta(douta0), .dvalida(dvalida0), .bursta_busy(bursta_busy0), .bursta_done(bursta_done0),
    .reb(reb), .web(web), .addrb(addrb), .dinb(dinb),
    .burstb_start(burstb_start), .burstb_addr(burstb_addr), .burstb_len(burstb_len),
    .doutb(doutb0), .dvalidb(dvalidb0), .burstb_busy(burstb_busy0), .burstb_done(burstb_done0)
  );

  dual_port_ram_burst #(.RD_LATENCY(3), .COLLISION_MODE(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .rea(rea), .wea(wea), .addra(addra), .dina(dina),
    .bursta_start(bursta_start), .bursta_addr(bursta_addr), .bursta_len(bursta_len),
    .douta(douta1), .dvalida(dvalida1), .bursta_busy(bursta_busy1), .bursta_done(bursta_done1),
    .reb(reb), .web(web), .addrb(addrb), .dinb(dinb),
    .burstb_start(burstb_start), .burstb_addr(burstb_addr), .burstb_len(burstb_len),
    .doutb(doutb1), .dvalidb(dvalidb1), .burstb_busy(burstb_busy1), .burstb_done(burstb_done1)
  );

  logic [37:0] obs0, obs1, exp0, exp1;
  assign obs0 = {douta0, dvalida0, bursta_busy0, bursta_done0, doutb0, dvalidb0, burstb_busy0, burstb_done0};
  assign obs1 = {douta1, dvalida1, bursta_busy1, bursta_done1, doutb1, dvalidb1, burstb_busy1, burstb_done1};

  int total = 0;
  int bad   = 0;

  // Reference model: per instance memory, outstanding burst words, and a
  // queue of promised read results keyed by the cycle they must appear.
  typedef struct {
    int          due;
    logic [15:0] d;
    bit          done;
  } ent_t;

  logic [15:0] mm [2][DEEP];
  int          left [2][2];
  int          cur  [2][2];
  ent_t        q    [4][$];
  int          cyc = 0;

  function automatic int lat(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  task automatic model_reset();
    for (int j = 0; j < 4; j++) q[j].delete();
    for (int i = 0; i < 2; i++)
      for (int p = 0; p < 2; p++) begin
        left[i][p] = 0;
        cur[i][p]  = 0;
      end
  endtask

  task automatic model_step();
    bit   re_v [2], we_v [2], st_v [2], wr [2];
    int   ad [2], ba [2], bl [2];
    logic [15:0] dv [2];
    ent_t e;
    re_v = '{rea, reb};  we_v = '{wea, web};  st_v = '{bursta_start, burstb_start};
    ad   = '{int'(addra), int'(addrb)};
    ba   = '{int'(bursta_addr), int'(burstb_addr)};
    bl   = '{int'(bursta_len), int'(burstb_len)};
    dv   = '{dina, dinb};
    cyc++;
    for (int i = 0; i < 2; i++) begin
      for (int p = 0; p < 2; p++) begin
        wr[p] = 1'b0;
        if (left[i][p] > 0) begin
          e.due = cyc + lat(i) - 1; e.d = mm[i][cur[i][p]]; e.done = (left[i][p] == 1);
          q[i*2+p].push_back(e);
          cur[i][p] = (cur[i][p] + 1) % DEEP;
          left[i][p]--;
        end else begin
          if (re_v[p]) begin
            e.due = cyc + lat(i) - 1; e.d = (ad[p] < DEEP) ? mm[i][ad[p]] : 16'h0; e.done = 1'b0;
            q[i*2+p].push_back(e);
          end
          wr[p] = we_v[p] && (ad[p] < DEEP);
          if (st_v[p] && bl[p] != 0 && ba[p] < DEEP) begin
            left[i][p] = bl[p];
            cur[i][p]  = ba[p];
          end
        end
      end
      if (wr[0] && wr[1] && ad[0] == ad[1]) mm[i][ad[0]] = (i == 0) ? dv[0] : dv[1];
      else begin
        if (wr[0]) mm[i][ad[0]] = dv[0];
        if (wr[1]) mm[i][ad[1]] = dv[1];
      end
    end
  endtask

  task automatic model_expect();
    logic [18:0] pv [2];
    logic [37:0] ev [2];
    for (int i = 0; i < 2; i++) begin
      for (int p = 0; p < 2; p++) begin
        int j = i*2 + p;
        while (q[j].size() > 0 && q[j][0].due < cyc) void'(q[j].pop_front());
        pv[p] = {16'h0, 1'b0, left[i][p] > 0, 1'b0};
        if (q[j].size() > 0 && q[j][0].due == cyc)
          pv[p] = {q[j][0].d, 1'b1, left[i][p] > 0, q[j][0].done};
      end
      ev[i] = {pv[0], pv[1]};
    end
    exp0 = ev[0];
    exp1 = ev[1];
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    else cyc++;
    #1;
    model_expect();
  endtask

  task automatic clear_inputs();
    rea = 0; wea = 0; reb = 0; web = 0;
    addra = '0; addrb = '0; dina = '0; dinb = '0;
    bursta_start = 0; burstb_start = 0;
    bursta_addr = '0; burstb_addr = '0; bursta_len = '0; burstb_len = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    model_reset();
    repeat (3) tick();
    total++;
    if (obs0 !== 38'h0 || obs1 !== 38'h0) begin
      bad++;
      $display("FAIL reset_outputs: got %h/%h want 0/0", obs0, obs1);
    end
    rst_n = 1'b1;
    tick();
    total++;
    if ({obs0, obs1} !== {exp0, exp1}) begin
      bad++;
      $display("FAIL reset_release: got %h/%h want %h/%h", obs0, obs1, exp0, exp1);
    end
  endtask

  task automatic test_fill();
    for (int a = 0; a < DEEP; a++) begin
      clear_inputs();
      wea = 1; addra = 6'(a); dina = 16'($urandom);
      tick();
      total++;
      if ({obs0, obs1} !== {exp0, exp1}) begin
        bad++;
        $display("FAIL fill a=%0d: got %h/%h want %h/%h", a, obs0, obs1, exp0, exp1);
      end
    end
  endtask

  task automatic test_write_read();
    logic [33:0] want;
    clear_inputs();
    wea = 1; addra = 6'd5; dina = 16'h1234;
    tick();
    clear_inputs();
    reb = 1; addrb = 6'd5;
    for (int k = 1; k <= 4; k++) begin
      tick();
      clear_inputs();
      want = {k == 1, (k == 1) ? 16'h1234 : 16'h0, k == 3, (k == 3) ? 16'h1234 : 16'h0};
      total++;
      if ({dvalidb0, doutb0, dvalidb1, doutb1} !== want || {obs0, obs1} !== {exp0, exp1}) begin
        bad++;
        $display("FAIL write_read k=%0d: got %h/%h want %h (model %h/%h)", k, obs0, obs1, want, exp0, exp1);
      end
    end
  endtask

  task automatic test_latency();
    logic [15:0] vals [3];
    logic [33:0] want;
    vals = '{16'd10, 16'd20, 16'd30};
    for (int a = 0; a < 3; a++) begin
      clear_inputs();
      wea = 1; addra = 6'(a); dina = vals[a];
      tick();
    end
    for (int k = 1; k <= 7; k++) begin
      clear_inputs();
      if (k <= 3) begin rea = 1; addra = 6'(k - 1); end
      tick();
      want = '0;
      if (k <= 3)           want[33:17] = {1'b1, vals[k-1]};
      if (k >= 3 && k <= 5) want[16:0]  = {1'b1, vals[k-3]};
      total++;
      if ({dvalida0, douta0, dvalida1, douta1} !== want || {obs0, obs1} !== {exp0, exp1}) begin
        bad++;
        $display("FAIL latency k=%0d: got %h/%h want %h (model %h/%h)", k, obs0, obs1, want, exp0, exp1);
      end
    end
  endtask

  task automatic test_burst_wrap();
    int          busy_n, done_n, nwords;
    logic [15:0] words [8];
    int          seed_addr [4];
    seed_addr = '{38, 39, 0, 1};
    for (int a = 0; a < 4; a++) begin
      clear_inputs();
      wea = 1; addra = 6'(seed_addr[a]); dina = 16'(a + 1);
      tick();
    end
    busy_n = 0; done_n = 0; nwords = 0;
    for (int k = 0; k <= 8; k++) begin
      clear_inputs();
      if (k == 0) begin bursta_start = 1; bursta_addr = 6'd38; bursta_len = 7'd4; end
      if (k == 2) begin rea = 1; wea = 1; addra = 6'd39; dina = 16'hFFFF; end
      tick();
      if (bursta_busy0) busy_n++;
      if (bursta_done0) done_n++;
      if (dvalida0 && nwords < 8) begin words[nwords] = douta0; nwords++; end
      total++;
      if ({obs0, obs1} !== {exp0, exp1}) begin
        bad++;
        $display("FAIL burst_wrap k=%0d: got %h/%h want %h/%h", k, obs0, obs1, exp0, exp1);
      end
    end
    total++;
    if (busy_n != 4 || done_n != 1 || nwords != 4 ||
        words[0] !== 16'd1 || words[1] !== 16'd2 || words[2] !== 16'd3 || words[3] !== 16'd4) begin
      bad++;
      $display("FAIL burst_stream: busy=%0d done=%0d words=%0d first=%h want busy=4 done=1 words=4 1,2,3,4",
               busy_n, done_n, nwords, words[0]);
    end
    clear_inputs();
    rea = 1; addra = 6'd39;
    tick();
    clear_inputs();
    total++;
    if (douta0 !== 16'd2 || dvalida0 !== 1'b1) begin
      bad++;
      $display("FAIL burst_write_ignored: got %h want 0002", douta0);
    end
    repeat (3) tick();
  endtask

  task automatic test_collision();
    clear_inputs();
    wea = 1; web = 1; addra = 6'd7; addrb = 6'd7; dina = 16'hAAAA; dinb = 16'hBBBB;
    tick();
    clear_inputs();
    rea = 1; addra = 6'd7;
    tick();
    clear_inputs();
    total++;
    if (douta0 !== 16'hAAAA || {obs0, obs1} !== {exp0, exp1}) begin
      bad++;
      $display("FAIL collision_a_wins: got %h want aaaa", douta0);
    end
    tick();
    tick();
    total++;
    if (douta1 !== 16'hBBBB || dvalida1 !== 1'b1 || {obs0, obs1} !== {exp0, exp1}) begin
      bad++;
      $display("FAIL collision_b_wins: got %h want bbbb", douta1);
    end
  endtask

  task automatic test_rw_oor();
    clear_inputs();
    wea = 1; addra = 6'd3; dina = 16'h0011;
    tick();
    clear_inputs();
    rea = 1; addra = 6'd3; web = 1; addrb = 6'd3; dinb = 16'h0022;
    tick();
    clear_inputs();
    total++;
    if (douta0 !== 16'h0011 || {obs0, obs1} !== {exp0, exp1}) begin
      bad++;
      $display("FAIL read_first: got %h want 0011", douta0);
    end
    rea = 1; addra = 6'd3;
    tick();
    clear_inputs();
    total++;
    if (douta0 !== 16'h0022 || {obs0, obs1} !== {exp0, exp1}) begin
      bad++;
      $display("FAIL read_after_write: got %h want 0022", douta0);
    end
    wea = 1; addra = 6'd45; dina = 16'hDEAD;
    tick();
    clear_inputs();
    rea = 1; addra = 6'd45;
    tick();
    clear_inputs();
    total++;
    if (douta0 !== 16'h0 || dvalida0 !== 1'b1 || {obs0, obs1} !== {exp0, exp1}) begin
      bad++;
      $display("FAIL out_of_range: got dout=%h dvalid=%b want 0000/1", douta0, dvalida0);
    end
    repeat (3) begin
      tick();
      total++;
      if ({obs0, obs1} !== {exp0, exp1}) begin
        bad++;
        $display("FAIL rw_drain: got %h/%h want %h/%h", obs0, obs1, exp0, exp1);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    int cnt;
    clear_inputs();
    burstb_start = 1; burstb_addr = 6'd0; burstb_len = 7'd10;
    tick();
    clear_inputs();
    cnt = 0;
    for (int k = 0; k < 20 && cnt < 3; k++) begin
      tick();
      if (dvalidb0) cnt++;
    end
    total++;
    if (cnt != 3) begin
      bad++;
      $display("FAIL burst_words_before_reset: got %0d want 3", cnt);
    end
    rst_n = 1'b0;
    model_reset();
    #1;
    total++;
    if (obs0 !== 38'h0 || obs1 !== 38'h0) begin
      bad++;
      $display("FAIL reset_mid_burst: got %h/%h want 0/0", obs0, obs1);
    end
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 15; k++) begin
      tick();
      total++;
      if (dvalidb0 || dvalidb1 || burstb_done0 || burstb_done1 || {obs0, obs1} !== {exp0, exp1}) begin
        bad++;
        $display("FAIL after_reset k=%0d: got %h/%h want %h/%h", k, obs0, obs1, exp0, exp1);
      end
    end
    burstb_start = 1; burstb_addr = 6'd2; burstb_len = 7'd0;
    tick();
    clear_inputs();
    tick();
    total++;
    if (burstb_busy0 || burstb_busy1 || {obs0, obs1} !== {exp0, exp1}) begin
      bad++;
      $display("FAIL zero_len_burst: got busy=%b%b want 00", burstb_busy0, burstb_busy1);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      clear_inputs();
      rea   = ($urandom_range(0, 2) == 0);
      wea   = ($urandom_range(0, 2) == 0);
      reb   = ($urandom_range(0, 2) == 0);
      web   = ($urandom_range(0, 2) == 0);
      addra = 6'($urandom_range(0, 47));
      addrb = ($urandom_range(0, 3) == 0) ? addra : 6'($urandom_range(0, 47));
      dina  = 16'($urandom);
      dinb  = 16'($urandom);
      bursta_start = ($urandom_range(0, 11) == 0);
      burstb_start = ($urandom_range(0, 11) == 0);
      bursta_addr  = 6'($urandom_range(0, 44));
      burstb_addr  = 6'($urandom_range(0, 44));
      bursta_len   = 7'($urandom_range(0, 45));
      burstb_len   = 7'($urandom_range(0, 45));
      tick();
      total++;
      if ({obs0, obs1} !== {exp0, exp1}) begin
        bad++;
        $display("FAIL random k=%0d: got %h/%h want %h/%h", k, obs0, obs1, exp0, exp1);
      end
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_write_read();
    test_latency();
    test_burst_wrap();
    test_collision();
    test_rw_oor();
    test_reset_mid_burst();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dual_port_ram_burst.md
Name: dual_port_ram_burst

Overview:
- Parametrised true-dual-port RAM for the Fully_Connected datapath (weight/activation buffers).
- Adds configurable read latency, deterministic write-collision resolution, address range checking and a per-port burst-read sequencer.
- The burst sequencer lets a port stream consecutive words (with wrap-around) into the MAC array from a single start command.

Parameters:
RAM_DEEP, 40, number of words
DWIDTH, 16, data width in bits
AWIDTH, $clog2(RAM_DEEP), address width
LWIDTH, AWIDTH+1, burst length width
RD_LATENCY, 1, request-to-data cycles; legal 1..3
COLLISION_MODE, 0, same-address dual write winner: 0 = port A, 1 = port B

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
rea  in  1  port A single read request
wea  in  1  port A write enable
addra  in  AWIDTH  port A address
dina  in  DWIDTH  port A write data
bursta_start  in  1  port A burst start pulse
bursta_addr  in  AWIDTH  port A burst start address
bursta_len  in  LWIDTH  port A burst word count
douta  out  DWIDTH  port A read data
dvalida  out  1  port A read data valid
bursta_busy  out  1  port A burst in progress
bursta_done  out  1  port A last burst word valid (1-cycle pulse)
reb, web, addrb, dinb, burstb_start, burstb_addr, burstb_len  in  (as port A)  port B equivalents
doutb, dvalidb, burstb_busy, burstb_done  out  (as port A)  port B equivalents

Behaviour:
- Reset: single clock; asynchronous, active-low reset (rst_n).
  - Assertion clears all outputs to 0, empties the read pipelines and aborts any burst.
  - Memory contents are not reset.
  - Reset mid-burst: no further dvalid or done pulses; data already in the pipeline is discarded.
- Per-port FSM: IDLE -> BURST on start when len != 0 and bursta_addr < RAM_DEEP.
  - Otherwise start is ignored; start while busy is ignored.
  - BURST issues one read per cycle at cur_addr. After the last issue it returns to IDLE.
  - busy = 1 for exactly len cycles, beginning the cycle after start.
- Burst addressing: cur_addr increments by 1 per issue and wraps from RAM_DEEP-1 to 0. len > RAM_DEEP is legal and repeats words.
- Request arbitration (per port):
  - While busy, rea/wea on that port are ignored.
  - In IDLE, rea and wea may be asserted together:
    - The read returns the old contents (read-first).
    - The write still occurs.
- Read latency:
  - A request issued in cycle N gives dout/dvalid at N+RD_LATENCY.
  - The pipeline is RD_LATENCY stages deep and fully pipelined, so one result is returned per cycle.
  - dout = 0 whenever dvalid = 0.
- burst_done is asserted together with dvalid of the final burst word, via a tag carried in the pipeline.
- Out-of-range address (>= RAM_DEEP):
  - Writes are dropped.
  - Single reads return dout = 0 with dvalid = 1.
- Collisions:
  - Both ports write the same address in the same cycle: the COLLISION_MODE port wins; the other write is lost.
  - One port reads an address while the other writes it in the same cycle: the read returns the old data.
  - Different addresses: fully independent.
- Writes take effect at the clock edge. A read issued the following cycle sees the new data.

Test Plan:
- Write mem[5] = 16'h1234 via A, then read addr 5 via B next cycle with RD_LATENCY=1 -> doutb = 16'h1234, dvalidb = 1 exactly one cycle after reb.
- RD_LATENCY=3: back-to-back A reads at addresses 0, 1, 2 preloaded with 10, 20, 30 -> douta = 10, 20, 30 on three consecutive cycles starting 3 cycles after the first request; dvalida low otherwise and douta = 0.
- Burst on A: addr = 38, len = 4, RAM_DEEP = 40, mem[38, 39, 0, 1] = 1, 2, 3, 4 -> douta stream 1, 2, 3, 4; bursta_done with word 4 only; busy high 4 cycles; rea pulsed mid-burst has no effect.
- Simultaneous writes to addr 7 (A = 16'hAAAA, B = 16'hBBBB) with COLLISION_MODE=0 -> subsequent read 16'hAAAA; repeat with mode 1 -> 16'hBBBB.
- Same-cycle A read / B write at addr 3 (old 16'h0011, new 16'h0022) -> douta = 16'h0011; later read gives 16'h0022. Write to addr 45 dropped; read of addr 45 -> 0 with dvalid = 1.
- Start burst len = 10 on B, drop rst_n after 3 data words -> all outputs 0 immediately; no further dvalidb or burstb_done after release; burstb_start with len = 0 -> busy stays 0.
